// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port and unified-memory port shared by the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the pipeline and memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one fixed-latency, single-ported memory between instruction fetch and data access.
// Data accesses win by default. A starvation counter forces a fetch after STARVE_MAX data grants in a row.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              owner_dm;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [31:0]       if_rdata_q;
  logic              if_valid_q, dm_valid_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic grant_dm;
  assign grant_dm = bus.dm_req && !(bus.if_req && starve_cnt == SC_W'(STARVE_MAX));

  // NOTE: all state uses non-blocking assignments and the asynchronous reset,
  // so a reset mid-access drops mem_en/mem_we at once and cancels the pending valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner_dm    <= 1'b0;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            owner_dm    <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            lat_cnt     <= LAT_W'(MEM_LAT - 1);
            state       <= ACCESS;
            if (bus.if_req && starve_cnt != SC_W'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
            else if (!bus.if_req)
              starve_cnt <= '0;
          end else if (bus.if_req) begin
            owner_dm    <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            lat_cnt     <= LAT_W'(MEM_LAT - 1);
            state       <= ACCESS;
            starve_cnt  <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state    <= RESP;
            if (owner_dm) begin
              dm_valid_q <= 1'b1;
              if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
endmodule
